sram_stage_sequencer: RTL and testbench

- Parametrised top-level SRAM owner and flow sequencer for the decoder.
- Arbitrates one external SRAM port among VGA (idle), the UART loader, and NUM_STAGES decode stages (e.g. M2 then M1).
- Sequences UART load -> stage 0 .. stage N-1 -> idle, using start/done handshakes.
- Adds over the fixed two-stage flow: runtime stage-skip mask, programmable UART timeout, sequence-done pulse, active-stage reporting.

---
 rtl/sram_seq_pkg.sv | 19 +
 rtl/sram_port_mux.sv | 75 +++++++
 rtl/sram_stage_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_sram_stage_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_seq_pkg : shared state encoding and constants for the SRAM sequencer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sram_seq_pkg;

  typedef enum logic [1:0] {
    S_SEQ_IDLE      = 2'd0,
    S_SEQ_UART_RX   = 2'd1,
    S_SEQ_STAGE_RUN = 2'd2,
    S_SEQ_STAGE_GAP = 2'd3
  } seq_state_t;

  // Truncated to the active-stage width at the point of use; all-ones there.
  localparam logic [7:0] NO_STAGE = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/sram_port_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_port_mux : zero-latency SRAM port selection by sequencer state      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sram_port_mux
  import sram_seq_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int IDX_W      = $clog2(NUM_STAGES) + 1
) (
  input  seq_state_t                   state_i,
  input  logic [IDX_W-1:0]             idx_i,
  input  logic [ADDR_W-1:0]            vga_address_i,
  input  logic [ADDR_W-1:0]            uart_address_i,
  input  logic [DATA_W-1:0]            uart_write_data_i,
  input  logic                         uart_we_n_i,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_address_i,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_write_data_i,
  input  logic [NUM_STAGES-1:0]        stage_we_n_i,
  output logic [ADDR_W-1:0]            sram_address_o,
  output logic [DATA_W-1:0]            sram_write_data_o,
  output logic                         sram_we_n_o
);

  logic [ADDR_W-1:0] stg_addr_w;
  logic [DATA_W-1:0] stg_data_w;
  logic              stg_we_n_w;

  // Compare-based select keeps an out-of-range index (NO_STAGE) harmless.
  always_comb begin
    stg_addr_w = '0;
    stg_data_w = '0;
    stg_we_n_w = 1'b1;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx_i == IDX_W'(i)) begin
        stg_addr_w = stage_address_i[i*ADDR_W +: ADDR_W];
        stg_data_w = stage_write_data_i[i*DATA_W +: DATA_W];
        stg_we_n_w = stage_we_n_i[i];
      end
    end
  end

  always_comb begin
    sram_address_o    = vga_address_i;
    sram_write_data_o = uart_write_data_i;
    sram_we_n_o       = 1'b1;
    case (state_i)
      S_SEQ_UART_RX: begin
        sram_address_o    = uart_address_i;
        sram_write_data_o = uart_write_data_i;
        sram_we_n_o       = uart_we_n_i;
      end
      S_SEQ_STAGE_RUN: begin
        sram_address_o    = stg_addr_w;
        sram_write_data_o = stg_data_w;
        sram_we_n_o       = stg_we_n_w;
      end
      S_SEQ_STAGE_GAP: begin
        sram_address_o    = stg_addr_w;
        sram_write_data_o = stg_data_w;
        sram_we_n_o       = 1'b1;
      end
      default: begin
        sram_address_o    = vga_address_i;
        sram_write_data_o = uart_write_data_i;
        sram_we_n_o       = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sram_stage_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_stage_sequencer : SRAM owner, UART load -> decode stages -> VGA flow |
// | Optional stage watchdog via SEQ_WATCHDOG_EN.   Rev 1.0                    |
// +--------------------------------------------------------------------------+
module sram_stage_sequencer
  import sram_seq_pkg::*;
#(
  parameter int NUM_STAGES   = 2,
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int UART_TIMEOUT = 50000000,
  parameter int TMR_W        = 26
`ifdef SEQ_WATCHDOG_EN
  , parameter int WDT_CYCLES = 2**24
`endif
) (
  input  logic                          CLOCK_50_I,
  input  logic                          resetn,
  input  logic                          uart_rx_i,
  output logic                          uart_rx_initialize,
  output logic                          uart_rx_enable,
  input  logic [ADDR_W-1:0]             uart_address,
  input  logic [DATA_W-1:0]             uart_write_data,
  input  logic                          uart_we_n,
  input  logic [ADDR_W-1:0]             vga_address,
  output logic                          vga_enable,
  input  logic [NUM_STAGES-1:0]         stage_skip,
  output logic [NUM_STAGES-1:0]         stage_start,
  input  logic [NUM_STAGES-1:0]         stage_done,
  input  logic [NUM_STAGES*ADDR_W-1:0]  stage_address,
  input  logic [NUM_STAGES*DATA_W-1:0]  stage_write_data,
  input  logic [NUM_STAGES-1:0]         stage_we_n,
  output logic [ADDR_W-1:0]             sram_address,
  output logic [DATA_W-1:0]             sram_write_data,
  output logic                          sram_we_n,
  output logic [$clog2(NUM_STAGES):0]   active_stage,
  output logic                          seq_done
`ifdef SEQ_WATCHDOG_EN
  , output logic                        wdt_err
`endif
);

  localparam int                IDX_W    = $clog2(NUM_STAGES) + 1;
  localparam logic [IDX_W-1:0]  IDX_NONE = IDX_W'(NO_STAGE);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(UART_TIMEOUT - 1);
`ifdef SEQ_WATCHDOG_EN
  localparam logic [31:0]       WDT_LAST = 32'(WDT_CYCLES - 1);
`endif

  seq_state_t            state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [NUM_STAGES-1:0] start_q, start_d;
  logic [NUM_STAGES-1:0] skip_q, skip_d;
  logic [IDX_W-1:0]      active_q, active_d;
  logic                  vga_q, vga_d;
  logic                  init_q, init_d;
  logic                  en_q, en_d;
  logic                  done_q, done_d;
  logic [IDX_W-1:0]      nxt;
`ifdef SEQ_WATCHDOG_EN
  logic [31:0]           wdt_cnt_q, wdt_cnt_d;
  logic                  wdt_err_q, wdt_err_d;
`endif

  // Lowest non-skipped index, either from 0 or strictly above 'after'.
  function automatic logic [IDX_W-1:0] pick_stage(input logic [NUM_STAGES-1:0] skip,
                                                  input logic [IDX_W-1:0]      after,
                                                  input logic                  from_zero);
    logic [IDX_W-1:0] sel;
    sel = IDX_NONE;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!skip[i] && (from_zero || (IDX_W'(i) > after)))
        sel = IDX_W'(i);
    end
    return sel;
  endfunction

  function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_STAGES-1:0] v;
    for (int i = 0; i < NUM_STAGES; i++)
      v[i] = (idx == IDX_W'(i));
    return v;
  endfunction

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_SEQ_IDLE;
      timer_q   <= '0;
      start_q   <= '0;
      skip_q    <= '0;
      active_q  <= IDX_NONE;
      vga_q     <= 1'b1;
      init_q    <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wdt_cnt_q <= '0;
      wdt_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      start_q   <= start_d;
      skip_q    <= skip_d;
      active_q  <= active_d;
      vga_q     <= vga_d;
      init_q    <= init_d;
      en_q      <= en_d;
      done_q    <= done_d;
`ifdef SEQ_WATCHDOG_EN
      wdt_cnt_q <= wdt_cnt_d;
      wdt_err_q <= wdt_err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    start_d   = start_q;
    skip_d    = skip_q;
    active_d  = active_q;
    vga_d     = vga_q;
    init_d    = 1'b0;
    en_d      = 1'b0;
    done_d    = 1'b0;
    nxt       = IDX_NONE;
`ifdef SEQ_WATCHDOG_EN
    wdt_cnt_d = wdt_cnt_q;
    wdt_err_d = wdt_err_q;
`endif
    case (state_q)
      S_SEQ_IDLE: begin
        vga_d = 1'b1;
        if (!uart_rx_i) begin
          init_d  = 1'b1;
          timer_d = '0;
          vga_d   = 1'b0;
          state_d = S_SEQ_UART_RX;
        end
      end
      S_SEQ_UART_RX: begin
        en_d = init_q;
        if (!uart_we_n) begin
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          // The skip mask is captured once here and governs the whole run.
          skip_d = stage_skip;
          nxt    = pick_stage(stage_skip, IDX_NONE, 1'b1);
          if (nxt == IDX_NONE) begin
            done_d  = 1'b1;
            vga_d   = 1'b1;
            state_d = S_SEQ_IDLE;
          end else begin
            start_d  = stage_onehot(nxt);
            active_d = nxt;
            state_d  = S_SEQ_STAGE_RUN;
`ifdef SEQ_WATCHDOG_EN
            wdt_cnt_d = '0;
`endif
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_SEQ_STAGE_RUN: begin
        if (|(stage_done & start_q)) begin
          start_d = '0;
          state_d = S_SEQ_STAGE_GAP;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wdt_cnt_q == WDT_LAST) begin
          start_d   = '0;
          wdt_err_d = 1'b1;
          vga_d     = 1'b1;
          active_d  = IDX_NONE;
          state_d   = S_SEQ_IDLE;
        end else begin
          wdt_cnt_d = wdt_cnt_q + 32'd1;
        end
`endif
      end
      S_SEQ_STAGE_GAP: begin
        nxt = pick_stage(skip_q, active_q, 1'b0);
        if (nxt == IDX_NONE) begin
          done_d   = 1'b1;
          vga_d    = 1'b1;
          active_d = IDX_NONE;
          state_d  = S_SEQ_IDLE;
        end else begin
          start_d  = stage_onehot(nxt);
          active_d = nxt;
          state_d  = S_SEQ_STAGE_RUN;
`ifdef SEQ_WATCHDOG_EN
          wdt_cnt_d = '0;
`endif
        end
      end
      default: state_d = S_SEQ_IDLE;
    endcase
  end

  assign uart_rx_initialize = init_q;
  assign uart_rx_enable     = en_q;
  assign vga_enable         = vga_q;
  assign stage_start        = start_q;
  assign active_stage       = active_q;
  assign seq_done           = done_q;
`ifdef SEQ_WATCHDOG_EN
  assign wdt_err            = wdt_err_q;
`endif

  sram_port_mux #(
    .NUM_STAGES (NUM_STAGES),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .IDX_W      (IDX_W)
  ) u_port_mux (
    .state_i            (state_q),
    .idx_i              (active_q),
    .vga_address_i      (vga_address),
    .uart_address_i     (uart_address),
    .uart_write_data_i  (uart_write_data),
    .uart_we_n_i        (uart_we_n),
    .stage_address_i    (stage_address),
    .stage_write_data_i (stage_write_data),
    .stage_we_n_i       (stage_we_n),
    .sram_address_o     (sram_address),
    .sram_write_data_o  (sram_write_data),
    .sram_we_n_o        (sram_we_n)
  );

endmodule
`default_nettype wire

// File: tb/tb_sram_stage_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_sram_stage_sequencer : directed vectors for the SRAM stage sequencer  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sram_stage_sequencer;

  localparam int NS  = 2;
  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int TMO = 100;
  localparam int TW  = 8;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            uart_rx_i = 1'b1;
  logic            uart_rx_initialize, uart_rx_enable;
  logic [AW-1:0]   uart_address = '0;
  logic [DW-1:0]   uart_write_data = '0;
  logic            uart_we_n = 1'b1;
  logic [AW-1:0]   vga_address = 18'h01234;
  logic            vga_enable;
  logic [NS-1:0]   stage_skip = '0;
  logic [NS-1:0]   stage_start;
  logic [NS-1:0]   stage_done = '0;
  logic [NS*AW-1:0] stage_address = '0;
  logic [NS*DW-1:0] stage_write_data = '0;
  logic [NS-1:0]   stage_we_n = '1;
  logic [AW-1:0]   sram_address;
  logic [DW-1:0]   sram_write_data;
  logic            sram_we_n;
  logic [1:0]      active_stage;
  logic            seq_done;
`ifdef SEQ_WATCHDOG_EN
  logic            wdt_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  sram_stage_sequencer #(
    .NUM_STAGES   (NS),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .UART_TIMEOUT (TMO),
    .TMR_W        (TW)
`ifdef SEQ_WATCHDOG_EN
    , .WDT_CYCLES (64)
`endif
  ) dut (
    .CLOCK_50_I         (clk),
    .resetn             (resetn),
    .uart_rx_i          (uart_rx_i),
    .uart_rx_initialize (uart_rx_initialize),
    .uart_rx_enable     (uart_rx_enable),
    .uart_address       (uart_address),
    .uart_write_data    (uart_write_data),
    .uart_we_n          (uart_we_n),
    .vga_address        (vga_address),
    .vga_enable         (vga_enable),
    .stage_skip         (stage_skip),
    .stage_start        (stage_start),
    .stage_done         (stage_done),
    .stage_address      (stage_address),
    .stage_write_data   (stage_write_data),
    .stage_we_n         (stage_we_n),
    .sram_address       (sram_address),
    .sram_write_data    (sram_write_data),
    .sram_we_n          (sram_we_n),
    .active_stage       (active_stage),
    .seq_done           (seq_done)
`ifdef SEQ_WATCHDOG_EN
    , .wdt_err          (wdt_err)
`endif
  );

  typedef struct {
    logic [1:0] skip;
    logic [1:0] first;
    logic [1:0] first_idx;
    logic [1:0] second;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Start bit for one cycle; returns just after the edge that entered UART_RX.
  task automatic trigger();
    uart_rx_i = 1'b0;
    step();
    uart_rx_i = 1'b1;
  endtask

  task automatic uart_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    uart_we_n = 1'b0;
    uart_address = a;
    uart_write_data = d;
    #1;
    chk("uart_mux_addr", 32'(sram_address), 32'(a));
    chk("uart_mux_we", 32'(sram_we_n), 32'd0);
    step();
    uart_we_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{skip: 2'b00, first: 2'b01, first_idx: 2'd0, second: 2'b10};
    vecs[1] = '{skip: 2'b01, first: 2'b10, first_idx: 2'd1, second: 2'b00};
    vecs[2] = '{skip: 2'b10, first: 2'b01, first_idx: 2'd0, second: 2'b00};
    vecs[3] = '{skip: 2'b11, first: 2'b00, first_idx: 2'd3, second: 2'b00};

    // Reset state
    resetn = 1'b0;
    steps(2);
    chk("rst_vga", 32'(vga_enable), 32'd1);
    chk("rst_init", 32'(uart_rx_initialize), 32'd0);
    chk("rst_en", 32'(uart_rx_enable), 32'd0);
    chk("rst_start", 32'(stage_start), 32'd0);
    chk("rst_done", 32'(seq_done), 32'd0);
    chk("rst_active", 32'(active_stage), 32'd3);
    chk("rst_addr", 32'(sram_address), 32'h01234);
    chk("rst_we", 32'(sram_we_n), 32'd1);
    resetn = 1'b1;
    step();

    // UART start handshake
    trigger();
    chk("init_pulse", 32'(uart_rx_initialize), 32'd1);
    chk("init_vga", 32'(vga_enable), 32'd0);
    chk("init_en_early", 32'(uart_rx_enable), 32'd0);
    step();
    chk("init_drop", 32'(uart_rx_initialize), 32'd0);
    chk("en_pulse", 32'(uart_rx_enable), 32'd1);
    step();
    chk("en_drop", 32'(uart_rx_enable), 32'd0);

    // Writes at 0, 50, 120 then silence
    uart_write(18'h00AAA, 16'h5A5A);
    steps(49);
    uart_write(18'h00BBB, 16'h1111);
    steps(69);
    uart_write(18'h00CCC, 16'h2222);
    steps(99);
    chk("tmo_before", 32'(stage_start), 32'd0);
    step();
    chk("tmo_start", 32'(stage_start), 32'b01);
    chk("tmo_active", 32'(active_stage), 32'd0);

    stage_skip = 2'b11;
    stage_address = {18'h3ABCD, 18'h01111};
    #1;
    chk("run0_addr", 32'(sram_address), 32'h01111);
    stage_done = 2'b10;
    step();
    stage_done = 2'b00;
    chk("ignore_other_done", 32'(stage_start), 32'b01);
    stage_done = 2'b01;
    step();
    stage_done = 2'b00;
    stage_we_n = 2'b10;
    #1;
    chk("gap_start", 32'(stage_start), 32'd0);
    chk("gap_we_forced", 32'(sram_we_n), 32'd1);
    chk("gap_addr", 32'(sram_address), 32'h01111);
    step();
    stage_we_n = 2'b01;
    stage_write_data = {16'hBEEF, 16'h1234};
    #1;
    chk("run1_start", 32'(stage_start), 32'b10);
    chk("run1_active", 32'(active_stage), 32'd1);
    chk("run1_addr", 32'(sram_address), 32'h3ABCD);
    chk("run1_we", 32'(sram_we_n), 32'd0);
    chk("run1_data", 32'(sram_write_data), 32'hBEEF);
    stage_we_n = 2'b11;
    uart_rx_i = 1'b0;
    step();
    uart_rx_i = 1'b1;
    chk("no_rx_outside_idle", 32'(uart_rx_initialize), 32'd0);
    stage_done = 2'b10;
    step();
    stage_done = 2'b00;
    chk("last_gap_done", 32'(seq_done), 32'd0);
    step();
    chk("seq_done_pulse", 32'(seq_done), 32'd1);
    chk("seq_done_vga", 32'(vga_enable), 32'd1);
    chk("seq_done_active", 32'(active_stage), 32'd3);
    chk("seq_done_addr", 32'(sram_address), 32'h01234);
    step();
    chk("seq_done_drop", 32'(seq_done), 32'd0);
    stage_skip = 2'b00;

    // Skip-mask table
    for (int v = 0; v < 4; v++) begin
      stage_skip = vecs[v].skip;
      trigger();
      steps(99);
      chk("tbl_wait", 32'(stage_start), 32'd0);
      step();
      chk("tbl_first", 32'(stage_start), 32'(vecs[v].first));
      stage_skip = ~vecs[v].skip;
      if (vecs[v].first == 2'b00) begin
        chk("tbl_allskip_done", 32'(seq_done), 32'd1);
        chk("tbl_allskip_vga", 32'(vga_enable), 32'd1);
        step();
        chk("tbl_allskip_drop", 32'(seq_done), 32'd0);
      end else begin
        chk("tbl_first_idx", 32'(active_stage), 32'(vecs[v].first_idx));
        stage_done = vecs[v].first;
        step();
        stage_done = 2'b00;
        chk("tbl_gap", 32'(stage_start), 32'd0);
        step();
        chk("tbl_second", 32'(stage_start), 32'(vecs[v].second));
        chk("tbl_done_after_first", 32'(seq_done), 32'(vecs[v].second == 2'b00));
        if (vecs[v].second != 2'b00) begin
          stage_done = vecs[v].second;
          step();
          stage_done = 2'b00;
          step();
          chk("tbl_done_after_second", 32'(seq_done), 32'd1);
        end
        step();
      end
      stage_skip = 2'b00;
    end

    // Asynchronous reset while stage 1 runs
    trigger();
    steps(100);
    stage_done = 2'b01;
    step();
    stage_done = 2'b00;
    step();
    chk("pre_rst_start", 32'(stage_start), 32'b10);
    #5;
    resetn = 1'b0;
    #1;
    chk("arst_start", 32'(stage_start), 32'd0);
    chk("arst_vga", 32'(vga_enable), 32'd1);
    chk("arst_active", 32'(active_stage), 32'd3);
    step();
    resetn = 1'b1;
    step();
    chk("post_rst_idle_addr", 32'(sram_address), 32'h01234);
    chk("post_rst_init", 32'(uart_rx_initialize), 32'd0);

`ifdef SEQ_WATCHDOG_EN
    trigger();
    steps(100);
    chk("wdt_run", 32'(stage_start), 32'b01);
    steps(63);
    chk("wdt_not_yet", 32'(wdt_err), 32'd0);
    step();
    chk("wdt_err", 32'(wdt_err), 32'd1);
    chk("wdt_start_drop", 32'(stage_start), 32'd0);
    chk("wdt_vga", 32'(vga_enable), 32'd1);
    chk("wdt_no_done", 32'(seq_done), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
